// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the cordic front-end blocks.
//   - FSM state encoding for the rotation sequencer
//   - default word width and matching x_init gain constant
//   - QUARTER / HALF binary-angle constants as functions of the word width
// Binary angle convention: +/-2^(BIT_WIDTH-1) == +/-180 degrees.
// ---------------------------------------------------------------------------
package cordic_pkg;

  // Default word width of angle and vector words.
  localparam int unsigned DEF_BIT_WIDTH = 8;

  // round(0.60725 * (2^(DEF_BIT_WIDTH-1) - 1)); recompute if the width changes.
  localparam int unsigned DEF_X_GAIN = 77;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // 90 degrees in binary-angle units.
  function automatic int unsigned quarter_angle(input int unsigned bw);
    return 32'd1 << (bw - 32'd2);
  endfunction

  // 180 degrees in binary-angle units.
  function automatic int unsigned half_angle(input int unsigned bw);
    return 32'd1 << (bw - 32'd1);
  endfunction

endpackage : cordic_pkg

// File: rtl/cordic_angle_fold.sv
// ---------------------------------------------------------------------------
// cordic_angle_fold
// Purely combinational quadrant fold of a binary angle into the cordic
// convergence range (+/-90 degrees). Angles beyond +/-90 degrees are shifted
// by 180 degrees (MSB inversion) and a flip flag tells the consumer to
// negate the resulting x/y. Shared by the rotation and vectoring front ends.
//
// Build option: CORDIC_QUAD_FOLD_EN
//   defined     : fold applied
//   not defined : angle passes through unchanged, flip tied to 0
//
// Ports:
//   angle         in  BIT_WIDTH  signed binary angle
//   fold_angle_c  out BIT_WIDTH  folded angle (combinational)
//   fold_flip_c   out 1          fold applied; negate x/y downstream
// ---------------------------------------------------------------------------
module cordic_angle_fold
  import cordic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] angle,
  output logic [BIT_WIDTH-1:0] fold_angle_c,
  output logic                 fold_flip_c
);

`ifdef CORDIC_QUAD_FOLD_EN
  // One extra bit so +/-QUARTER compare without overflow.
  localparam logic signed [BIT_WIDTH:0] QTR_P =
    (BIT_WIDTH+1)'(quarter_angle(BIT_WIDTH));
  localparam logic signed [BIT_WIDTH:0] QTR_N = -QTR_P;

  logic signed [BIT_WIDTH:0] angle_ext;
  logic                      beyond;

  always_comb begin
    angle_ext = $signed({angle[BIT_WIDTH-1], angle});
    // Exactly +/-90 degrees is already inside the convergence range.
    beyond    = (angle_ext > QTR_P) || (angle_ext < QTR_N);
    fold_flip_c  = beyond;
    fold_angle_c = angle;
    // Adding 180 degrees modulo 360 is an MSB inversion.
    if (beyond) begin
      fold_angle_c = {~angle[BIT_WIDTH-1], angle[BIT_WIDTH-2:0]};
    end
  end
`else
  always_comb begin
    fold_angle_c = angle;
    fold_flip_c  = 1'b0;
  end
`endif

endmodule : cordic_angle_fold

// File: rtl/cordic_seq_in.sv
// ---------------------------------------------------------------------------
// cordic_seq_in
// Upstream sequencer for the iterative cordic_comp core (rotation mode).
// Takes one target angle per valid/ready transaction, folds it into the
// core's convergence range, loads the core's x/y/z start vector under its
// load reset, counts ITERATIONS core clocks and strobes res_valid in the
// cycle the core outputs are final, together with the sign fix-up flag.
//
// Build option: CORDIC_QUAD_FOLD_EN (see cordic_angle_fold); without it the
// angle is passed through unfolded and res_flip stays 0.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   s_angle    in   BIT_WIDTH  target binary angle (+/-2^(BIT_WIDTH-1) = 180 deg)
//   s_valid    in   1          angle valid
//   s_ready    out  1          angle can be accepted
//   abort      in   1          synchronous cancel of the in-flight rotation
//   core_rst   out  1          load/reset strobe to the core
//   x_init     out  BIT_WIDTH  core x start value
//   y_init     out  BIT_WIDTH  core y start value
//   z_init     out  BIT_WIDTH  core z start value (folded angle)
//   res_valid  out  1          one-cycle strobe: core outputs are final
//   res_flip   out  1          negate core x/y downstream; valid with res_valid
//
// Timing: accept edge k -> LOAD cycle -> ITERATIONS ITER cycles -> DONE
// cycle (after edge k+ITERATIONS+1) -> IDLE. One rotation per
// ITERATIONS+3 cycles.
// ---------------------------------------------------------------------------
module cordic_seq_in
  import cordic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int unsigned ITERATIONS = BIT_WIDTH - 1,
  parameter int unsigned X_GAIN     = DEF_X_GAIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] s_angle,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 abort,
  output logic                 core_rst,
  output logic [BIT_WIDTH-1:0] x_init,
  output logic [BIT_WIDTH-1:0] y_init,
  output logic [BIT_WIDTH-1:0] z_init,
  output logic                 res_valid,
  output logic                 res_flip
);

  localparam int unsigned CNT_W = (ITERATIONS < 2) ? 1 : $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  logic [1:0]           state_q,     state_d;
  logic                 s_ready_q,   s_ready_d;
  logic                 core_rst_q,  core_rst_d;
  logic [BIT_WIDTH-1:0] x_init_q,    x_init_d;
  logic [BIT_WIDTH-1:0] y_init_q,    y_init_d;
  logic [BIT_WIDTH-1:0] z_init_q,    z_init_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_flip_q,  res_flip_d;
  logic                 flip_q,      flip_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;

  logic [BIT_WIDTH-1:0] fold_angle;
  logic                 fold_flip;
  logic                 accept;

  // Quadrant fold of the incoming angle.
  cordic_angle_fold #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_fold (
    .angle        (s_angle),
    .fold_angle_c (fold_angle),
    .fold_flip_c  (fold_flip)
  );

  assign accept = s_valid & s_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    s_ready_d   = 1'b0;
    core_rst_d  = 1'b1;
    x_init_d    = x_init_q;
    y_init_d    = y_init_q;
    z_init_d    = z_init_q;
    res_valid_d = 1'b0;
    res_flip_d  = 1'b0;
    flip_d      = flip_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // abort has no meaning here; an angle offered alongside it is taken.
        s_ready_d = 1'b1;
        if (accept) begin
          s_ready_d = 1'b0;
          flip_d    = fold_flip;
          x_init_d  = BIT_WIDTH'(X_GAIN);
          y_init_d  = '0;
          z_init_d  = fold_angle;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Core samples x/y/z_init under core_rst on this edge.
        core_rst_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_ITER;
        if (abort) begin
          core_rst_d = 1'b1;
          s_ready_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_ITER: begin
        core_rst_d = 1'b0;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_valid_d = 1'b1;
          res_flip_d  = flip_q;
          state_d     = ST_DONE;
        end
        // Abort wins, including over a DONE strobe about to be raised.
        if (abort) begin
          core_rst_d  = 1'b1;
          s_ready_d   = 1'b1;
          res_valid_d = 1'b0;
          res_flip_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_DONE: begin
        core_rst_d = 1'b1;
        s_ready_d  = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      core_rst_q  <= 1'b1;
      x_init_q    <= '0;
      y_init_q    <= '0;
      z_init_q    <= '0;
      res_valid_q <= 1'b0;
      res_flip_q  <= 1'b0;
      flip_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      core_rst_q  <= core_rst_d;
      x_init_q    <= x_init_d;
      y_init_q    <= y_init_d;
      z_init_q    <= z_init_d;
      res_valid_q <= res_valid_d;
      res_flip_q  <= res_flip_d;
      flip_q      <= flip_d;
      cnt_q       <= cnt_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign core_rst  = core_rst_q;
  assign x_init    = x_init_q;
  assign y_init    = y_init_q;
  assign z_init    = z_init_q;
  assign res_valid = res_valid_q;
  assign res_flip  = res_flip_q;

endmodule : cordic_seq_in

// File: tb/tb_cordic_seq_in.sv
// ---------------------------------------------------------------------------
// tb_cordic_seq_in
// Directed bench for cordic_seq_in (BIT_WIDTH=8, ITERATIONS=7, X_GAIN=77).
// A timeline model (cycles since acceptance) predicts every output each
// cycle; directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_cordic_seq_in;

  localparam int ITER     = 7;
  localparam int DONE_AGE = ITER + 1;   // cycles from LOAD (age 0) to result

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_angle;
  logic       s_valid;
  logic       s_ready;
  logic       abort;
  logic       core_rst;
  logic [7:0] x_init, y_init, z_init;
  logic       res_valid;
  logic       res_flip;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cordic_seq_in #(
    .BIT_WIDTH  (8),
    .ITERATIONS (ITER),
    .X_GAIN     (77)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_angle   (s_angle),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .abort     (abort),
    .core_rst  (core_rst),
    .x_init    (x_init),
    .y_init    (y_init),
    .z_init    (z_init),
    .res_valid (res_valid),
    .res_flip  (res_flip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fold rule in plain integer arithmetic.
  function automatic void fold_model(input int a, output logic [7:0] z, output logic f);
`ifdef CORDIC_QUAD_FOLD_EN
    if (a > 64 || a < -64) begin
      z = 8'((a + 128) % 256);
      f = 1'b1;
    end else begin
      z = 8'(a);
      f = 1'b0;
    end
`else
    z = 8'(a);
    f = 1'b0;
`endif
  endfunction

  // ---- timeline model: m_age = cycles since accept (-1 when idle) ----
  int         m_age;
  logic       m_ready;
  logic [7:0] m_x, m_y, m_z;
  logic       m_flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = -1; m_ready = 1'b0;
      m_x = 8'd0; m_y = 8'd0; m_z = 8'd0; m_flip = 1'b0;
    end else if (m_age < 0) begin
      if (s_valid && m_ready) begin
        m_age = 0; m_ready = 1'b0;
        m_x = 8'd77; m_y = 8'd0;
        fold_model(int'($signed(s_angle)), m_z, m_flip);
      end else begin
        m_ready = 1'b1;
      end
    end else if (abort || m_age == DONE_AGE) begin
      m_age = -1; m_ready = 1'b1;
    end else begin
      m_age++;
    end
  end

  // ---- compare process ----
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_s_ready",   32'(s_ready),   32'(m_ready));
      chk("m_core_rst",  32'(core_rst),  32'(m_age <= 0));
      chk("m_res_valid", 32'(res_valid), 32'(m_age == DONE_AGE));
      chk("m_x_init",    32'(x_init),    32'(m_x));
      chk("m_y_init",    32'(y_init),    32'(m_y));
      chk("m_z_init",    32'(z_init),    32'(m_z));
      if (m_age == DONE_AGE) chk("m_res_flip", 32'(res_flip), 32'(m_flip));
    end
  end

  // Offer an angle from a negedge; returns at the negedge of the LOAD cycle.
  task automatic send(input logic [7:0] a);
    bit ok = 0;
    s_angle = a;
    s_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  // Count negedges until res_valid is seen (bounded).
  task automatic wait_res(output int n, output logic flip);
    bit seen = 0;
    n = -1; flip = 1'bx;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (res_valid === 1'b1) begin
        seen = 1; n = i; flip = res_flip;
      end else begin
        @(negedge clk);
      end
    end
    chk("res_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic no_res(input string name, input int ncyc);
    int hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) hits++;
    end
    chk(name, 32'(hits), 32'd0);
  endtask

  int   n, t1, t2;
  logic fl;
  logic [7:0] ez;
  logic       ef;

  int         fa [4] = '{67, 64, -65, -128};
`ifdef CORDIC_QUAD_FOLD_EN
  logic [7:0] fz [4] = '{8'hC3, 8'h40, 8'h3F, 8'h00};
  logic       ff [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
`else
  logic [7:0] fz [4] = '{8'h43, 8'h40, 8'hBF, 8'h80};
  logic       ff [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; abort = 1'b0; s_angle = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    chk("rst_core_rst",  32'(core_rst),  32'd1);
    chk("rst_x_init",    32'(x_init),    32'd0);
    chk("rst_z_init",    32'(z_init),    32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_first_edge", 32'(s_ready), 32'd1);

    // Basic rotation, angle 32 (45 deg).
    send(8'd32);
    chk("load_core_rst", 32'(core_rst), 32'd1);
    chk("load_x_init",   32'(x_init),   32'd77);
    chk("load_y_init",   32'(y_init),   32'd0);
    chk("load_z_init",   32'(z_init),   32'd32);
    wait_res(n, fl);
    chk("latency_32", 32'(n), 32'd8);
    chk("flip_32",    32'(fl), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(s_ready), 32'd1);
    chk("strobe_one_cycle", 32'(res_valid), 32'd0);

    // Fold boundary cases.
    for (int i = 0; i < 4; i++) begin
      send(8'(fa[i]));
      chk($sformatf("fold_z_%0d", fa[i]), 32'(z_init), 32'(fz[i]));
      wait_res(n, fl);
      chk($sformatf("fold_flip_%0d", fa[i]), 32'(fl), 32'(ff[i]));
      @(negedge clk);
    end

    // Back-to-back with s_valid held high: 10 then 20.
    s_angle = 8'd10; s_valid = 1'b1;
    for (int i = 0; i < 40 && s_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    chk("b2b_z_first", 32'(z_init), 32'd10);
    s_angle = 8'd20;
    wait_res(n, fl);
    t1 = cyc;
    @(negedge clk);
    chk("b2b_ready_after_res", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("b2b_z_second", 32'(z_init), 32'd20);
    s_valid = 1'b0;
    wait_res(n, fl);
    t2 = cyc;
    chk("b2b_period", 32'(t2 - t1), 32'(ITER + 3));
    @(negedge clk);

    // Abort in the 4th ITER cycle.
    send(8'd50);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_core_rst",  32'(core_rst),  32'd1);
    chk("abort_s_ready",   32'(s_ready),   32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    no_res("abort_no_res", 15);
    send(8'hEC);   // -20
    chk("post_abort_z", 32'(z_init), 32'hEC);
    wait_res(n, fl);
    chk("post_abort_latency", 32'(n), 32'd8);
    chk("post_abort_flip", 32'(fl), 32'd0);
    @(negedge clk);

    // abort together with s_valid in IDLE: angle is taken.
    abort = 1'b1;
    send(8'd15);
    abort = 1'b0;
    chk("abort_idle_z", 32'(z_init), 32'd15);
    wait_res(n, fl);
    chk("abort_idle_latency", 32'(n), 32'd8);
    @(negedge clk);

    // Asynchronous reset pulse mid-ITER, between clock edges.
    send(8'd40);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_s_ready",   32'(s_ready),   32'd0);
    chk("arst_core_rst",  32'(core_rst),  32'd1);
    chk("arst_x_init",    32'(x_init),    32'd0);
    chk("arst_z_init",    32'(z_init),    32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    #1 rst = 1'b0;
    no_res("arst_no_res", 15);
    chk("arst_ready_again", 32'(s_ready), 32'd1);
    send(8'd100);
    fold_model(100, ez, ef);
    chk("arst_next_z", 32'(z_init), 32'(ez));
    wait_res(n, fl);
    chk("arst_next_latency", 32'(n), 32'd8);
    chk("arst_next_flip", 32'(fl), 32'(ef));
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cordic_seq_in
